// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: bus bundle for the PC / fetch sequencer.
// imem request/response, decode valid/ready, branch redirect.
interface pc_fetch_unit_if #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 16
);
  logic                   imemReq;
  logic [PC_WIDTH-1:0]    imemAddr;
  logic                   imemAck;
  logic [INSTR_WIDTH-1:0] imemData;
  logic                   instrValid;
  logic                   instrReady;
  logic [INSTR_WIDTH-1:0] instrOut;
  logic [PC_WIDTH-1:0]    instrPc;
  logic                   branchTaken;
  logic [PC_WIDTH-1:0]    branchTarget;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemAck,
    input  imemData,
    output instrValid,
    input  instrReady,
    output instrOut,
    output instrPc,
    input  branchTaken,
    input  branchTarget
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemAck,
    output imemData,
    input  instrValid,
    output instrReady,
    input  instrOut,
    input  instrPc,
    output branchTaken,
    output branchTarget
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the PC, fetches one instr at a time, hands it to decode.
// Ports: clk, rst_n (sync, active low), bus (master side), halted.
module pc_fetch_unit #(
  parameter int                     PC_WIDTH    = 16,
  parameter int                     INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = '1
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_fetch_unit_if.master bus,
  output logic            halted
);

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    HOLD,
    FLUSH,
    HALT
  } state_t;

  state_t                 state;
  logic                   reqQ;
  logic [PC_WIDTH-1:0]    pc;
  logic                   validQ;
  logic [INSTR_WIDTH-1:0] instrQ;
  logic [PC_WIDTH-1:0]    instrPcQ;
  logic                   haltedQ;

  logic [PC_WIDTH-1:0]    redirPc;
  logic [PC_WIDTH-1:0]    pcInc;
  logic                   accept;
  logic                   isHalt;

  assign redirPc = {bus.branchTarget[PC_WIDTH-1:1], 1'b0};
  assign pcInc   = pc + PC_WIDTH'(2);
  assign accept  = validQ & bus.instrReady;
  assign isHalt  = (instrQ == HALT_INSTR);

  // reqQ high in FETCH marks the cycle the pulse is on the bus;
  // the first FETCH cycle after reset raises it, later entries
  // into FETCH arrive with it already set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      reqQ     <= 1'b0;
      pc       <= RESET_PC;
      validQ   <= 1'b0;
      instrQ   <= '0;
      instrPcQ <= '0;
      haltedQ  <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (bus.branchTaken) begin
            pc     <= redirPc;
            validQ <= 1'b0;
            if (reqQ) begin
              // pulse already out: its ack is orphaned
              reqQ  <= 1'b0;
              state <= FLUSH;
            end else begin
              reqQ <= 1'b1;
            end
          end else if (reqQ) begin
            reqQ  <= 1'b0;
            state <= WAIT;
          end else begin
            reqQ <= 1'b1;
          end
        end

        WAIT: begin
          if (bus.branchTaken) begin
            pc     <= redirPc;
            validQ <= 1'b0;
            if (bus.imemAck) begin
              reqQ  <= 1'b1;
              state <= FETCH;
            end else begin
              state <= FLUSH;
            end
          end else if (bus.imemAck) begin
            instrQ   <= bus.imemData;
            instrPcQ <= pc;
            validQ   <= 1'b1;
            pc       <= pcInc;
            state    <= HOLD;
          end
        end

        HOLD: begin
          if (bus.branchTaken) begin
            pc     <= redirPc;
            validQ <= 1'b0;
            reqQ   <= 1'b1;
            state  <= FETCH;
          end else if (accept) begin
            validQ <= 1'b0;
            if (isHalt) begin
              haltedQ <= 1'b1;
              state   <= HALT;
            end else begin
              reqQ  <= 1'b1;
              state <= FETCH;
            end
          end
        end

        FLUSH: begin
          if (bus.branchTaken) begin
            pc <= redirPc;
          end
          if (bus.imemAck) begin
            reqQ  <= 1'b1;
            state <= FETCH;
          end
        end

        HALT: begin
          reqQ    <= 1'b0;
          validQ  <= 1'b0;
          haltedQ <= 1'b1;
        end

        default: begin
          reqQ  <= 1'b0;
          state <= FETCH;
        end
      endcase
    end
  end

  assign bus.imemReq    = reqQ;
  assign bus.imemAddr   = pc;
  assign bus.instrValid = validQ;
  assign bus.instrOut   = instrQ;
  assign bus.instrPc    = instrPcQ;
  assign halted         = haltedQ;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized bench with an architectural PC model.
// Memory responder and model live in tick(); tests compare inline.
module tb_pc_fetch_unit;

  logic clk;
  logic rst_n;
  logic halted;
  logic halted2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_unit_if bus ();
  pc_fetch_unit_if bus2 ();

  pc_fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .halted(halted)
  );

  pc_fetch_unit #(.RESET_PC(16'hFFFE)) dutWrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2),
    .halted(halted2)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic        sReq = 0, sValid = 0, sHalted = 0;
  logic [15:0] sAddr = 0, sOut = 0, sPc = 0;

  logic [15:0] expPc;
  bit          lastBranch, modelHalted, overlap;
  int          cnt, cnt2, memDelay;
  logic [15:0] pendAddr, pendAddr2;

  logic [15:0] accPc[$];
  logic [15:0] accOut[$];
  int          accCyc[$];
  logic [15:0] reqLog[$];
  logic [15:0] reqLog2[$];
  logic [15:0] patch[logic [15:0]];

  // even addresses give even words, so never the halt encoding
  function automatic logic [15:0] memWord(input logic [15:0] a);
    if (patch.exists(a)) return patch[a];
    return a ^ 16'h5A5A;
  endfunction

  task automatic tick();
    if (!rst_n) begin
      expPc       = 16'h0000;
      lastBranch  = 0;
      modelHalted = 0;
    end else begin
      lastBranch = 0;
      if (sValid && bus.instrReady) begin
        accPc.push_back(sPc);
        accOut.push_back(sOut);
        accCyc.push_back(cyc);
        expPc = expPc + 16'd2;
      end
      if (bus.branchTaken && !modelHalted) begin
        expPc      = bus.branchTarget & 16'hFFFE;
        lastBranch = 1;
      end else if (sValid && bus.instrReady && sOut == 16'hFFFF) begin
        modelHalted = 1;
      end
    end
    @(negedge clk);
    cyc++;
    sReq    = bus.imemReq;
    sAddr   = bus.imemAddr;
    sValid  = bus.instrValid;
    sOut    = bus.instrOut;
    sPc     = bus.instrPc;
    sHalted = halted;
    bus.imemAck  = 0;
    bus.imemData = 16'($urandom);
    bus2.imemAck = 0;
    bus2.imemData = 16'($urandom);
    if (!rst_n) begin
      cnt  = 0;
      cnt2 = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.imemAck  = 1;
          bus.imemData = memWord(pendAddr);
        end
      end
      if (sReq) begin
        if (cnt != 0) overlap = 1;
        pendAddr = sAddr;
        cnt      = memDelay;
        reqLog.push_back(sAddr);
      end
      if (cnt2 > 0) begin
        cnt2--;
        if (cnt2 == 0) begin
          bus2.imemAck  = 1;
          bus2.imemData = memWord(pendAddr2);
        end
      end
      if (bus2.imemReq) begin
        pendAddr2 = bus2.imemAddr;
        cnt2      = 1;
        reqLog2.push_back(bus2.imemAddr);
      end
    end
  endtask

  task automatic doReset();
    rst_n            = 0;
    bus.instrReady   = 0;
    bus.branchTaken  = 0;
    bus.branchTarget = 0;
    tick();
    tick();
    accPc.delete();
    accOut.delete();
    accCyc.delete();
    reqLog.delete();
    reqLog2.delete();
    patch.delete();
    overlap  = 0;
    memDelay = 1;
    rst_n    = 1;
  endtask

  task automatic test_reset();
    doReset();
    total++; if (sReq !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", sReq); end
    total++; if (sAddr !== 16'h0000) begin bad++; $display("FAIL rst_addr: got %h want 0000", sAddr); end
    total++; if (sValid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", sValid); end
    total++; if (sOut !== 16'h0000) begin bad++; $display("FAIL rst_instr: got %h want 0000", sOut); end
    total++; if (sPc !== 16'h0000) begin bad++; $display("FAIL rst_pc: got %h want 0000", sPc); end
    total++; if (sHalted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b want 0", sHalted); end
    total++; if (bus2.imemAddr !== 16'hFFFE) begin bad++; $display("FAIL rst_addr2: got %h want fffe", bus2.imemAddr); end
  endtask

  task automatic test_sequential();
    logic [15:0] want[3];
    want = '{16'h0000, 16'h0002, 16'h0004};
    doReset();
    bus.instrReady = 1;
    repeat (12) tick();
    total++;
    if (accPc.size() < 3) begin
      bad++; $display("FAIL seq_count: got %0d want >=3", accPc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (accPc[i] !== want[i]) begin bad++; $display("FAIL seq_pc%0d: got %h want %h", i, accPc[i], want[i]); end
        total++; if (accOut[i] !== memWord(want[i])) begin bad++; $display("FAIL seq_instr%0d: got %h want %h", i, accOut[i], memWord(want[i])); end
      end
      for (int i = 1; i < 3; i++) begin
        total++; if (accCyc[i] - accCyc[i-1] != 3) begin bad++; $display("FAIL seq_rate%0d: got %0d want 3", i, accCyc[i] - accCyc[i-1]); end
      end
    end
  endtask

  task automatic test_stall();
    int n = 0;
    doReset();
    patch[16'h0000] = 16'h1234;
    while (!sValid && n < 20) begin tick(); n++; end
    total++; if (sValid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", sValid); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (sOut !== 16'h1234) begin bad++; $display("FAIL stall_instr: got %h want 1234", sOut); end
      total++; if (sPc !== 16'h0000) begin bad++; $display("FAIL stall_pc: got %h want 0000", sPc); end
      total++; if (sValid !== 1'b1) begin bad++; $display("FAIL stall_hold: got %b want 1", sValid); end
      total++; if (sReq !== 1'b0) begin bad++; $display("FAIL stall_req: got %b want 0", sReq); end
    end
    bus.instrReady = 1;
    tick();
    tick();
    total++;
    if (accOut.size() != 1 || accOut[0] !== 16'h1234 || accPc[0] !== 16'h0000)
      begin bad++; $display("FAIL stall_accept: got n=%0d want one 1234@0000", accOut.size()); end
  endtask

  task automatic test_branch_hold();
    int n = 0;
    doReset();
    while (!sValid && n < 20) begin tick(); n++; end
    total++; if (sValid !== 1'b1) begin bad++; $display("FAIL bh_valid: got %b want 1", sValid); end
    bus.instrReady   = 1;
    bus.branchTaken  = 1;
    bus.branchTarget = 16'h0041;
    tick();
    bus.branchTaken  = 0;
    bus.branchTarget = 16'h0000;
    total++; if (sValid !== 1'b0) begin bad++; $display("FAIL bh_drop: got %b want 0", sValid); end
    n = 0;
    while (!sReq && n < 20) begin tick(); n++; end
    total++; if (sAddr !== 16'h0040 || sReq !== 1'b1) begin bad++; $display("FAIL bh_target: got %h want 0040", sAddr); end
    total++; if (accPc.size() != 1) begin bad++; $display("FAIL bh_accept: got %0d want 1", accPc.size()); end
    foreach (reqLog[i]) begin
      total++; if (reqLog[i] === 16'h0002) begin bad++; $display("FAIL bh_oldpc: got %h want not 0002", reqLog[i]); end
    end
    n = 0;
    while (!sValid && n < 20) begin tick(); n++; end
    total++; if (sPc !== 16'h0040) begin bad++; $display("FAIL bh_instrpc: got %h want 0040", sPc); end
    total++; if (sOut !== memWord(16'h0040)) begin bad++; $display("FAIL bh_instr: got %h want %h", sOut, memWord(16'h0040)); end
  endtask

  task automatic test_branch_wait();
    int n = 0;
    int beef = 0;
    doReset();
    patch[16'h0000] = 16'hBEEF;
    memDelay = 3;
    bus.instrReady = 1;
    while (!sReq && n < 20) begin tick(); n++; end
    total++; if (sReq !== 1'b1) begin bad++; $display("FAIL bw_req: got %b want 1", sReq); end
    tick();
    bus.branchTaken  = 1;
    bus.branchTarget = 16'h0100;
    memDelay = 1;
    tick();
    bus.branchTarget = 16'h0200;
    tick();
    bus.branchTaken  = 0;
    bus.branchTarget = 16'h0000;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (sValid && sOut === 16'hBEEF) beef++;
    end
    total++; if (beef != 0) begin bad++; $display("FAIL bw_beef: got %0d cycles want 0", beef); end
    total++;
    if (reqLog.size() < 2) begin bad++; $display("FAIL bw_reqs: got %0d want >=2", reqLog.size()); end
    else if (reqLog[1] !== 16'h0200) begin bad++; $display("FAIL bw_target: got %h want 0200", reqLog[1]); end
    total++;
    if (accPc.size() < 1) begin bad++; $display("FAIL bw_accn: got 0 want >=1"); end
    else if (accPc[0] !== 16'h0200) begin bad++; $display("FAIL bw_accpc: got %h want 0200", accPc[0]); end
  endtask

  task automatic test_wrap();
    doReset();
    repeat (12) tick();
    total++;
    if (reqLog2.size() < 2) begin bad++; $display("FAIL wrap_reqs: got %0d want >=2", reqLog2.size()); end
    else begin
      total++; if (reqLog2[0] !== 16'hFFFE) begin bad++; $display("FAIL wrap_first: got %h want fffe", reqLog2[0]); end
      total++; if (reqLog2[1] !== 16'h0000) begin bad++; $display("FAIL wrap_second: got %h want 0000", reqLog2[1]); end
    end
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 600; i++) begin
      tick();
      if (sValid) begin
        total++; if (sPc !== expPc) begin bad++; $display("FAIL rnd_pc c%0d: got %h want %h", cyc, sPc, expPc); end
        total++; if (sOut !== memWord(sPc)) begin bad++; $display("FAIL rnd_instr c%0d: got %h want %h", cyc, sOut, memWord(sPc)); end
      end
      if (lastBranch) begin
        total++; if (sValid !== 1'b0) begin bad++; $display("FAIL rnd_flush c%0d: got %b want 0", cyc, sValid); end
      end
      if (sReq) begin
        total++; if (sAddr !== expPc) begin bad++; $display("FAIL rnd_addr c%0d: got %h want %h", cyc, sAddr, expPc); end
      end
      total++; if (sHalted !== 1'b0) begin bad++; $display("FAIL rnd_halt c%0d: got %b want 0", cyc, sHalted); end
      bus.instrReady   = ($urandom % 4) != 0;
      memDelay         = $urandom_range(1, 3);
      bus.branchTaken  = ($urandom % 10) == 0;
      bus.branchTarget = 16'($urandom);
    end
    bus.branchTaken = 0;
    total++; if (overlap) begin bad++; $display("FAIL rnd_overlap: got 1 want 0"); end
    total++; if (accPc.size() < 20) begin bad++; $display("FAIL rnd_progress: got %0d want >=20", accPc.size()); end
  endtask

  task automatic test_halt();
    int n = 0;
    doReset();
    patch[16'h0004] = 16'hFFFF;
    bus.instrReady = 1;
    while (!sHalted && n < 40) begin tick(); n++; end
    total++; if (sHalted !== 1'b1) begin bad++; $display("FAIL halt_set: got %b want 1", sHalted); end
    total++;
    if (accPc.size() != 3) begin bad++; $display("FAIL halt_accn: got %0d want 3", accPc.size()); end
    else if (accPc[2] !== 16'h0004 || accOut[2] !== 16'hFFFF)
      begin bad++; $display("FAIL halt_last: got %h@%h want ffff@0004", accOut[2], accPc[2]); end
    for (int i = 0; i < 20; i++) begin
      bus.branchTaken  = $urandom_range(0, 1) == 1;
      bus.branchTarget = 16'($urandom);
      tick();
      total++; if (sReq !== 1'b0) begin bad++; $display("FAIL halt_req: got %b want 0", sReq); end
      total++; if (sValid !== 1'b0) begin bad++; $display("FAIL halt_valid: got %b want 0", sValid); end
      total++; if (sHalted !== 1'b1) begin bad++; $display("FAIL halt_stay: got %b want 1", sHalted); end
    end
    bus.branchTaken = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    total++; if (sHalted !== 1'b0) begin bad++; $display("FAIL halt_clear: got %b want 0", sHalted); end
    n = 0;
    while (!sReq && n < 20) begin tick(); n++; end
    total++; if (sReq !== 1'b1 || sAddr !== 16'h0000) begin bad++; $display("FAIL halt_refetch: got %b/%h want 1/0000", sReq, sAddr); end
  endtask

  initial begin
    rst_n             = 0;
    bus.imemAck       = 0;
    bus.imemData      = 0;
    bus.instrReady    = 0;
    bus.branchTaken   = 0;
    bus.branchTarget  = 0;
    bus2.imemAck      = 0;
    bus2.imemData     = 0;
    bus2.instrReady   = 1;
    bus2.branchTaken  = 0;
    bus2.branchTarget = 0;
    cnt = 0; cnt2 = 0; memDelay = 1; overlap = 0;
    expPc = 0; lastBranch = 0; modelHalted = 0;
    pendAddr = 0; pendAddr2 = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_hold();
    test_branch_wait();
    test_wrap();
    test_random();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
